// File: rtl/store_data_align_pkg.sv
// Shared store-path definitions: store-type codes (funct3), FSM states and
// the store-type to byte-mask mapping.
package store_data_align_pkg;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // An all-zero mask marks an illegal store type.
  function automatic logic [3:0] store_mask(input logic [2:0] st_type);
    logic [3:0] mask;
    case (st_type)
      ST_SB:   mask = 4'b0001;
      ST_SH:   mask = 4'b0011;
      ST_SW:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_data_align_lane_gen.sv
// Combinational lane generator: maps store type, byte offset and raw data to
// the 8-lane enable window, both beats' lane-shifted data and the crossing flag.
module store_lane_gen
  import store_data_align_pkg::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  off,
  input  logic [31:0] st_wdata,
  output logic [7:0]  ext,
  output logic [31:0] beat0_data,
  output logic [31:0] beat1_data,
  output logic        crossing,
  output logic        illegal
);

  logic [3:0]  mask_s;
  logic [63:0] wide_s;

  // Shift across a 64-bit window so the upper word is exactly the beat-1 data.
  always_comb begin
    mask_s     = store_mask(st_type);
    illegal    = (mask_s == 4'b0000);
    ext        = {4'b0000, mask_s} << off;
    wide_s     = {32'h0000_0000, st_wdata} << {off, 3'b000};
    beat0_data = wide_s[31:0];
    beat1_data = wide_s[63:32];
    crossing   = (ext[7:4] != 4'b0000);
  end

endmodule

// File: rtl/store_data_align.sv
// Store data aligner: turns a byte-addressed store into word-aligned RAM
// writes, splitting word-crossing stores into two registered beats.
module store_data_align
  import store_data_align_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [2:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  output logic              st_stall,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              st_misalign,
  output logic              st_err
);

  logic [7:0]        ext_s;
  logic [31:0]       beat0_data_s;
  logic [31:0]       beat1_data_s;
  logic              crossing_s;
  logic              illegal_s;
  logic              accept_s;
  logic [ADDR_W-1:0] word_addr_s;

  state_e            state_q,     state_d;
  logic [3:0]        mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              misalign_q,  misalign_d;
  logic              err_q,       err_d;
  logic [3:0]        b1_we_q,     b1_we_d;
  logic [ADDR_W-1:0] b1_addr_q,   b1_addr_d;
  logic [31:0]       b1_data_q,   b1_data_d;

  store_lane_gen u_lane_gen (
    .st_type    (st_type),
    .off        (st_addr[1:0]),
    .st_wdata   (st_wdata),
    .ext        (ext_s),
    .beat0_data (beat0_data_s),
    .beat1_data (beat1_data_s),
    .crossing   (crossing_s),
    .illegal    (illegal_s)
  );

  assign st_stall    = (state_q == SPLIT);
  assign accept_s    = st_valid && !st_stall;
  assign word_addr_s = {st_addr[ADDR_W-1:2], 2'b00};

  // Next-state and next-output selection; beat 1 is latched at acceptance.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    misalign_d  = 1'b0;
    err_d       = 1'b0;
    b1_we_d     = b1_we_q;
    b1_addr_d   = b1_addr_q;
    b1_data_d   = b1_data_q;
    case (state_q)
      IDLE: begin
        if (accept_s && illegal_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          mem_addr_d  = word_addr_s;
          mem_wdata_d = beat0_data_s;
          if (crossing_s && SPLIT_EN) begin
            mem_we_d  = ext_s[3:0];
            state_d   = SPLIT;
            b1_we_d   = ext_s[7:4];
            b1_addr_d = word_addr_s + ADDR_W'(4);
            b1_data_d = beat1_data_s;
          end else if (crossing_s) begin
            misalign_d = 1'b1;
          end else begin
            mem_we_d = ext_s[3:0];
          end
        end else begin
          mem_we_d = 4'b0000;
        end
      end
      SPLIT: begin
        mem_we_d    = b1_we_q;
        mem_addr_d  = b1_addr_q;
        mem_wdata_d = b1_data_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
      b1_we_q     <= 4'b0000;
      b1_addr_q   <= '0;
      b1_data_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
      b1_we_q     <= b1_we_d;
      b1_addr_q   <= b1_addr_d;
      b1_data_q   <= b1_data_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign st_misalign = misalign_q;
  assign st_err      = err_q;

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
- Write-side counterpart of the load data extender; sits between the MEM stage and the data RAM write port.
- Converts a store request (byte address, raw rs2 data, store type) into word-aligned RAM writes with byte-enables and lane-shifted data.
- Stores that cross a word boundary are split into two consecutive RAM writes. The pipeline is stalled for one extra cycle while the split completes.
- All RAM-side outputs are registered.

Parameters:
- ADDR_W, 32, byte address width
- SPLIT_EN, 1, 1 = split boundary-crossing stores into two beats; 0 = flag them via st_misalign and drop them

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- st_valid  in  1  store request present in MEM stage
- st_type  in  3  store type (`SB/`SH/`SW, funct3 encoding)
- st_addr  in  ADDR_W  byte address
- st_wdata  in  32  raw store data (rs2), LSB-justified
- st_stall  out  1  hold MEM stage; request not accepted this cycle
- mem_we  out  4  byte-lane write enables, lane i = bits [8i+7:8i]
- mem_addr  out  ADDR_W  word address, low two bits always 0
- mem_wdata  out  32  lane-shifted write data
- st_misalign  out  1  one-cycle pulse: crossing store dropped (SPLIT_EN=0)
- st_err  out  1  one-cycle pulse: illegal st_type

Behaviour:
- Reset values (rst high at a clk edge): mem_we=0, mem_addr=0, mem_wdata=0, st_misalign=0, st_err=0, state=IDLE. The pending second beat is discarded; reset mid-split never issues beat 1.
- Acceptance: the request is accepted at a clk edge when st_valid=1 and st_stall=0.
- Encodings: off = st_addr[1:0]. mask = 4'b0001 for `SB, 4'b0011 for `SH, 4'b1111 for `SW. ext = {4'b0, mask} << off, 8 bits wide.
- Beat 0, registered one cycle after acceptance:
  - mem_addr = {st_addr[ADDR_W-1:2], 2'b00}
  - mem_we = ext[3:0]
  - mem_wdata = st_wdata << (8*off)
- Crossing: a store crosses when ext[7:4] != 0 (`SH at off=3; `SW at off=1,2,3).
- Beat 1, only when crossing and SPLIT_EN=1, on the cycle after beat 0:
  - mem_addr = beat-0 address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000)
  - mem_we = ext[7:4]
  - mem_wdata = st_wdata >> (8*(4-off))
  - Beat-1 values are captured at acceptance.
- FSM states:
  - IDLE: accept a request. If crossing and SPLIT_EN=1, go to SPLIT; otherwise stay in IDLE.
  - SPLIT: emit beat 1 and return to IDLE. st_stall=1 for the whole cycle in which beat 0 is on the outputs. A new request cannot be accepted in that cycle.
- st_stall is combinational: 1 iff the next edge will emit beat 1. It is independent of st_valid.
- Idle cycles: when no request is accepted and no beat 1 is pending, the next edge drives mem_we=0. mem_addr and mem_wdata hold their previous values.
- SPLIT_EN=0 with a crossing store: beat 0 is emitted with mem_we=0 and st_misalign pulses for one cycle. There is no stall.
- Illegal st_type (not `SB/`SH/`SW) with st_valid=1: mem_we=0 and st_err pulses for one cycle. There is no stall and no state change.
- Throughput: back-to-back aligned stores run at one per cycle with no bubbles. A crossing store costs exactly 2 cycles.
- Bytes of mem_wdata outside the enabled lanes are don't-care to the RAM. The bench checks only the enabled lanes.

Decomposition:
- Add `SB=3'b000, `SH=3'b001 and `SW=3'b010 to the shared Parameters.v, alongside the existing load-type codes.
- Add the FSM state encodings IDLE/SPLIT as localparams.
- One natural sub-module: store_lane_gen, combinational. It maps (st_type, off, st_wdata) to ext[7:0], the beat-0 data, the beat-1 data and the crossing flag. The parent module holds the FSM and the output registers.

Test Plan:
- `SW addr=0x1000 data=0xDEADBEEF -> next cycle mem_addr=0x1000, mem_we=4'b1111, mem_wdata=0xDEADBEEF; st_stall=0.
- `SB addr=0x1002 data=0x000000A5 -> mem_we=4'b0100, mem_wdata[23:16]=0xA5. `SH addr=0x1001 data=0x1234 -> mem_we=4'b0110, mem_wdata[23:8]=0x1234.
- `SW addr=0x2003 data=0x11223344 -> beat 0: addr 0x2000, we=4'b1000, wdata[31:24]=0x44. Beat 1: addr 0x2004, we=4'b0111, wdata[23:0]=0x112233. st_stall=1 during beat 0. The next request is accepted only after the stall.
- Wrap: `SH addr=0xFFFFFFFF data=0xBEEF -> beat 0: addr 0xFFFFFFFC, we=4'b1000, byte 0xEF. Beat 1: addr 0x00000000, we=4'b0001, byte 0xBE.
- Reset asserted in the cycle beat 0 of a crossing `SW is on the outputs -> the next edge gives mem_we=0, st_stall=0, state IDLE, and no beat 1 ever appears.
- st_type=3'b111 with st_valid=1 -> mem_we=0 and a single-cycle st_err pulse. With SPLIT_EN=0, `SW addr=0x5 -> mem_we=0 and a single-cycle st_misalign pulse.
